// File: rtl/jt900h_pkg.sv
// Shared definitions for the JT900H bus controller: FSM states and chip-select codes.
package jt900h_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [1:0] CS_RAM = 2'b01;
   localparam logic [1:0] CS_ROM = 2'b10;

   // Anything above the first 2 MB is ROM.
   function automatic logic is_rom(input logic [23:0] addr);
      return addr[23:21] != 3'd0;
   endfunction

endpackage

// File: rtl/jt900h_waitcnt.sv
// Wait-state down-counter: loads a count, decrements while enabled, flags zero.
module jt900h_waitcnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/jt900h_busctl.sv
// JT900H external bus controller: IDLE/ACCESS/DONE sequencer with per-region wait states.
// Optional bus_wait timeout is enabled by defining JT900H_BUS_TIMEOUT_EN.
module jt900h_busctl
   import jt900h_pkg::*;
#(
   parameter int RAM_WAIT = 0,
   parameter int ROM_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        cpu_req,
   input  logic [23:0] cpu_addr,
   input  logic [15:0] cpu_din,
   input  logic [1:0]  cpu_we,
   output logic [15:0] cpu_dout,
   output logic        cpu_ack,
   output logic [22:0] bus_addr,
   output logic [15:0] bus_dout,
   input  logic [15:0] bus_din,
   output logic        bus_rd,
   output logic [1:0]  bus_wr,
   output logic [1:0]  bus_cs,
   input  logic        bus_wait,
   output logic        bus_err
);

   state_t      st, nxt;
   logic [22:0] lat_addr;
   logic [15:0] lat_din;
   logic [1:0]  lat_we;
   logic        lat_rom;
   logic        accept, last, wait_zero, tmo_hit, in_access;
   logic [3:0]  wait_val;
   logic        unused_addr0;

   // Byte address bit 0 is not visible on a word-wide bus.
   assign unused_addr0 = cpu_addr[0];

   assign accept    = cen && (st == ST_IDLE) && cpu_req;
   assign in_access = (st == ST_ACCESS);
   assign wait_val  = is_rom(cpu_addr) ? 4'(ROM_WAIT) : 4'(RAM_WAIT);
   assign last      = in_access && wait_zero && (!bus_wait || tmo_hit);

   jt900h_waitcnt #(.W(4)) u_waitcnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (wait_val),
      .en       (cen && in_access),
      .zero     (wait_zero)
   );

   always_ff @(posedge clk) begin
      if (rst)
         st <= ST_IDLE;
      else if (cen)
         st <= nxt;
   end

   always_comb begin
      nxt = st;
      case (st)
         ST_IDLE:   if (cpu_req) nxt = ST_ACCESS;
         ST_ACCESS: if (last)    nxt = ST_DONE;
         ST_DONE:                nxt = ST_IDLE;
         default:                nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_addr <= '0;
         lat_din  <= '0;
         lat_we   <= '0;
         lat_rom  <= 1'b0;
      end else if (accept) begin
         lat_addr <= cpu_addr[23:1];
         lat_din  <= cpu_din;
         lat_we   <= cpu_we;
         lat_rom  <= is_rom(cpu_addr);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         cpu_dout <= '0;
      else if (cen && last && lat_we == 2'b00)
         cpu_dout <= tmo_hit ? 16'hFFFF : bus_din;
   end

`ifdef JT900H_BUS_TIMEOUT_EN
   logic [7:0] tmo_cnt;
   logic       err_q;

   // Only cycles stretched by bus_wait count towards the timeout.
   assign tmo_hit = in_access && wait_zero && bus_wait && (tmo_cnt == 8'hFF);

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else if (cen) begin
         if (accept)
            tmo_cnt <= '0;
         else if (in_access && wait_zero && bus_wait && tmo_cnt != 8'hFF)
            tmo_cnt <= tmo_cnt + 8'd1;
         if (tmo_hit)
            err_q <= 1'b1;
      end
   end

   assign bus_err = err_q;
`else
   assign tmo_hit = 1'b0;
   assign bus_err = 1'b0;
`endif

   assign cpu_ack  = (st == ST_DONE);
   assign bus_cs   = in_access ? (lat_rom ? CS_ROM : CS_RAM) : 2'b00;
   assign bus_rd   = in_access && (lat_we == 2'b00);
   assign bus_wr   = in_access ? lat_we : 2'b00;
   assign bus_addr = lat_addr;
   assign bus_dout = lat_din;

endmodule

// File: tb/tb_jt900h_busctl.sv
// Directed and randomized bench for jt900h_busctl against a transaction-level model.
module tb_jt900h_busctl;

   localparam int RAM_W = 0;
   localparam int ROM_W = 2;

   logic        clk = 1'b0;
   logic        rst, cen, cpu_req, bus_wait;
   logic [23:0] cpu_addr;
   logic [15:0] cpu_din, bus_din;
   logic [1:0]  cpu_we;
   logic [15:0] cpu_dout, bus_dout;
   logic        cpu_ack, bus_rd, bus_err;
   logic [22:0] bus_addr;
   logic [1:0]  bus_wr, bus_cs;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] model_dout;
   logic        model_err;

   always #5 clk = ~clk;

   jt900h_busctl #(.RAM_WAIT(RAM_W), .ROM_WAIT(ROM_W)) dut (
      .clk(clk), .rst(rst), .cen(cen), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
      .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din), .bus_rd(bus_rd),
      .bus_wr(bus_wr), .bus_cs(bus_cs), .bus_wait(bus_wait), .bus_err(bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ack"}, 32'(cpu_ack), 32'd0);
      chk({tag, "_cs"},  32'(bus_cs),  32'd0);
      chk({tag, "_rd"},  32'(bus_rd),  32'd0);
      chk({tag, "_wr"},  32'(bus_wr),  32'd0);
   endtask

   // One complete request. Access length = 1 + region wait + bus_wait extensions;
   // bus_wait is held high from the start so early highs must be ignored.
   task automatic run_txn(input string tag, input logic [23:0] addr, input logic [15:0] din,
                          input logic [1:0] we, input int nwait, input bit tog,
                          input logic [15:0] rdata);
      bit          rom, timeout;
      int          w, ext, a, idx, clks;
      logic [1:0]  exp_cs;
      logic [15:0] new_dout;
      rom     = (addr[23:21] != 3'd0);
      w       = rom ? ROM_W : RAM_W;
      timeout = 1'b0;
      ext     = nwait;
`ifdef JT900H_BUS_TIMEOUT_EN
      if (nwait > 255) begin
         timeout = 1'b1;
         ext     = 255;
      end
`endif
      a        = 1 + w + ext;
      exp_cs   = rom ? 2'b10 : 2'b01;
      new_dout = (we == 2'b00) ? (timeout ? 16'hFFFF : rdata) : model_dout;
      idx      = 0;
      clks     = 0;
      cpu_req  = 1'b1;
      cpu_addr = addr;
      cpu_din  = din;
      cpu_we   = we;
      cen      = 1'b1;
      bus_wait = 1'b0;
      bus_din  = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      forever begin
         if (idx < a) begin
            chk({tag, "_cs"},    32'(bus_cs),   32'(exp_cs));
            chk({tag, "_addr"},  32'(bus_addr), 32'(addr[23:1]));
            chk({tag, "_rd"},    32'(bus_rd),   32'(we == 2'b00));
            chk({tag, "_wr"},    32'(bus_wr),   32'(we));
            chk({tag, "_bdout"}, 32'(bus_dout), 32'(din));
            chk({tag, "_ack0"},  32'(cpu_ack),  32'd0);
            chk({tag, "_dout0"}, 32'(cpu_dout), 32'(model_dout));
            chk({tag, "_err0"},  32'(bus_err),  32'(model_err));
         end else if (idx == a) begin
            chk({tag, "_ack"},   32'(cpu_ack),  32'd1);
            chk({tag, "_dcs"},   32'(bus_cs),   32'd0);
            chk({tag, "_drd"},   32'(bus_rd),   32'd0);
            chk({tag, "_dwr"},   32'(bus_wr),   32'd0);
            chk({tag, "_dout"},  32'(cpu_dout), 32'(new_dout));
            chk({tag, "_err"},   32'(bus_err),  32'(model_err | timeout));
         end else begin
            chk_idle_outputs({tag, "_idle"});
            model_dout = new_dout;
            model_err  = model_err | timeout;
            break;
         end
         if (clks >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_bound: stuck at step %0d expected end at %0d", tag, idx, a + 1);
            model_dout = new_dout;
            model_err  = model_err | timeout;
            break;
         end
         cpu_addr = 24'($urandom);
         cpu_din  = 16'($urandom);
         cpu_we   = 2'($urandom);
         cen      = tog ? 1'($urandom_range(0, 1)) : 1'b1;
         bus_wait = (idx < w + nwait);
         bus_din  = (idx == a - 1) ? rdata : 16'($urandom);
         @(posedge clk);
         if (cen) idx++;
         clks++;
         @(negedge clk);
      end
      cpu_req  = 1'b0;
      cen      = 1'b1;
      bus_wait = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk_idle_outputs(tag);
      chk({tag, "_dout"},  32'(cpu_dout), 32'd0);
      chk({tag, "_err"},   32'(bus_err),  32'd0);
      chk({tag, "_baddr"}, 32'(bus_addr), 32'd0);
      chk({tag, "_bdout"}, 32'(bus_dout), 32'd0);
   endtask

   logic [23:0] r_addr;
   logic [1:0]  r_we;

   initial begin
      rst = 1'b1; cen = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_din = '0;
      cpu_we = '0; bus_din = '0; bus_wait = 1'b0;
      model_dout = '0;
      model_err  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      cen = 1'b1;
      @(negedge clk);

      run_txn("ram_rd",    24'h000102, 16'h0000, 2'b00, 0, 1'b0, 16'hBEEF);
      run_txn("rom_wr",    24'h200001, 16'h5A5A, 2'b10, 0, 1'b0, 16'h0000);
      run_txn("ram_wait5", 24'h000200, 16'h0000, 2'b00, 5, 1'b0, 16'h1234);
      run_txn("rom_cen",   24'h400000, 16'h0000, 2'b00, 0, 1'b1, 16'hCAFE);
      run_txn("wr_keep",   24'h000010, 16'h7777, 2'b11, 1, 1'b1, 16'h9999);

      // Abort a ROM read in its second access cycle; reset must win over cen=0.
      cpu_req = 1'b1; cpu_addr = 24'h300010; cpu_we = 2'b00; cpu_din = 16'h1111; cen = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_cs1", 32'(bus_cs), 32'h2);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      cen = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_state("abort");
      rst = 1'b0;
      cpu_req = 1'b0;
      cen = 1'b1;
      model_dout = '0;
      model_err  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("abort_noack", 32'(cpu_ack), 32'd0);
      end
      run_txn("after_abort", 24'h000040, 16'h0000, 2'b00, 0, 1'b0, 16'h4321);

      for (int i = 0; i < 12; i++) begin
         r_addr = 24'($urandom);
         if ($urandom_range(0, 1) == 1) r_addr[23:21] = 3'd0;
         r_we = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
         run_txn("rand", r_addr, 16'($urandom), r_we, $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), 16'($urandom));
      end

`ifdef JT900H_BUS_TIMEOUT_EN
      run_txn("tmo",      24'h000300, 16'h0000, 2'b00, 400, 1'b0, 16'h2222);
      run_txn("tmo_keep", 24'h000302, 16'h0000, 2'b00, 0,   1'b0, 16'h3333);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_state("tmo_rst");
      rst = 1'b0;
      model_dout = '0;
      model_err  = 1'b0;
      @(negedge clk);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
